// File: rtl/score_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_pkg
//  Description : Shared types and constants for the score display block:
//                converter FSM state encoding, digit/score widths, the blank
//                segment pattern and the 0-9 active-low segment table.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package score_display_pkg;

    localparam int DIGITS  = 4;
    localparam int SCORE_W = 10;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int CNT_W   = 4;

    // Converter FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Active-low segments, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Codes above 9 cannot arise from the converter; show them dark anyway.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        if (digit <= 4'd9) pattern = SEG_TABLE[digit];
        else               pattern = SEG_BLANK;
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_display_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-add-3 (double dabble) binary to BCD
//                converter, one bit per clock.
//  Ports       : clock  - clock, rising edge
//                reset  - asynchronous active-low reset
//                start  - accept value (honoured only while idle)
//                value  - binary input, SCORE_W bits
//                busy   - high while shifting or finishing
//                done   - one-cycle pulse when bcd updates
//                bcd    - last converted result, DIGITS BCD nibbles
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    localparam logic [CNT_W-1:0] c_last_shift = CNT_W'(SCORE_W - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [SCORE_W-1:0]         r_shift;
    logic [BCD_W-1:0]           r_acc;
    logic [BCD_W-1:0]           w_acc_adj;
    logic [BCD_W+SCORE_W-1:0]   w_shifted;
    logic [CNT_W-1:0]           r_cnt;
    logic [BCD_W-1:0]           r_bcd;
    logic                       r_done;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == c_last_shift) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state != ST_IDLE);
        done = r_done;
        bcd  = r_bcd;
    end

    // Add 3 to every nibble that would overflow past 9 after doubling.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_acc_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5)
                                        ? r_acc[gi*4 +: 4] + 4'd3
                                        : r_acc[gi*4 +: 4];
        end
    endgenerate

    assign w_shifted = {w_acc_adj, r_shift} << 1;

    // ---------------- Datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift <= value;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_acc   <= w_shifted[BCD_W+SCORE_W-1:SCORE_W];
                    r_shift <= w_shifted[SCORE_W-1:0];
                    r_cnt   <= r_cnt + 1'b1;
                end
                ST_DONE: begin
                    r_bcd  <= r_acc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
//  Module      : score_display
//  Description : Converts a changing binary score to BCD and drives a
//                4-digit multiplexed active-low 7-segment display with
//                leading-zero blanking.
//  Ports       : clock     - clock, rising edge
//                reset     - asynchronous active-low reset
//                score     - binary score 0..1023
//                bcd       - last converted value, [15:12] = thousands
//                conv_done - one-cycle pulse when bcd updates
//                busy      - high while a conversion runs
//                seg       - active-low segments, seg[0]=a ... seg[6]=g
//                digit_sel - active-low one-hot digit enable, bit0 = units
//  Revision    : 1.0 - initial release
// ============================================================================
module score_display
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    output logic [BCD_W-1:0]   bcd,
    output logic               conv_done,
    output logic               busy,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  digit_sel
);

    localparam logic [15:0] c_scan_max = 16'(SCAN_DIV - 1);

    logic [SCORE_W-1:0] r_last_score;
    logic               w_start;

    logic [15:0]        r_scan_cnt;
    logic [15:0]        w_scan_cnt_nxt;
    logic               w_wrap;
    logic [1:0]         r_digit_idx;
    logic [1:0]         w_digit_idx_nxt;
    logic [3:0]         w_nibble;
    logic               w_lead_zero;
    logic               w_blank;
    logic [6:0]         w_seg_nxt;
    logic [6:0]         r_seg;
    logic [DIGITS-1:0]  w_digit_sel_nxt;
    logic [DIGITS-1:0]  r_digit_sel;

    // A new conversion is requested only while the converter is idle, so a
    // score that moved during a conversion is picked up right afterwards.
    assign w_start = !busy && (score != r_last_score);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       r_last_score <= '0;
        else if (w_start) r_last_score <= score;
    end

    bin2bcd_seq u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (w_start),
        .value (score),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // ---------------- Scan timing ----------------
    always_comb begin
        w_wrap          = (r_scan_cnt == c_scan_max);
        w_scan_cnt_nxt  = w_wrap ? 16'd0 : r_scan_cnt + 16'd1;
        w_digit_idx_nxt = w_wrap ? r_digit_idx + 2'd1 : r_digit_idx;
    end

    // ---------------- Digit decode ----------------
    // Segment and select registers are both loaded from the next digit index,
    // so they always refer to the same digit. Only the committed bcd is used.
    always_comb begin
        w_nibble    = bcd[{w_digit_idx_nxt, 2'b00} +: 4];
        w_lead_zero = 1'b1;
        w_blank     = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_lead_zero = w_lead_zero && (bcd[i*4 +: 4] == 4'd0);
            if (2'(i) == w_digit_idx_nxt) w_blank = w_lead_zero;
        end
        w_seg_nxt       = w_blank ? SEG_BLANK : seg_decode(w_nibble);
        w_digit_sel_nxt = ~(4'b0001 << w_digit_idx_nxt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_scan_cnt  <= 16'd0;
            r_digit_idx <= 2'd0;
            r_seg       <= 7'b1000000;
            r_digit_sel <= 4'b1110;
        end else begin
            r_scan_cnt  <= w_scan_cnt_nxt;
            r_digit_idx <= w_digit_idx_nxt;
            r_seg       <= w_seg_nxt;
            r_digit_sel <= w_digit_sel_nxt;
        end
    end

    assign seg       = r_seg;
    assign digit_sel = r_digit_sel;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_display
//  Description : Self-checking bench for score_display with SCAN_DIV = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

    logic        clock;
    logic        reset;
    logic [9:0]  score;
    logic [15:0] bcd;
    logic        conv_done;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  digit_sel;

    int checks = 0;
    int errors = 0;

    score_display #(.SCAN_DIV(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .score     (score),
        .bcd       (bcd),
        .conv_done (conv_done),
        .busy      (busy),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]      score;
        logic [15:0]     bcd;
        logic [3:0][6:0] seg;   // {thousands, hundreds, tens, units}
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Waits from the sampling edge; returns edges until conv_done (-1 on timeout).
    task automatic wait_conv(output int lat);
        lat = -1;
        @(posedge clock);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (conv_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_conv(input logic [9:0] s, output int lat);
        score = s;
        wait_conv(lat);
    endtask

    // Observe one full scan period and compare each digit's segments.
    task automatic scan_check(input logic [3:0][6:0] exp_seg, input string tag);
        logic [6:0] obs [4];
        logic       bad_sel;
        bad_sel = 1'b0;
        for (int d = 0; d < 4; d++) obs[d] = 7'h00;
        repeat (2) @(posedge clock);
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            case (digit_sel)
                4'b1110: obs[0] = seg;
                4'b1101: obs[1] = seg;
                4'b1011: obs[2] = seg;
                4'b0111: obs[3] = seg;
                default: bad_sel = 1'b1;
            endcase
        end
        chk({tag, " digit_sel one-hot-low"}, {31'd0, bad_sel}, 32'd0);
        for (int d = 0; d < 4; d++)
            chk($sformatf("%s seg digit%0d", tag, d), {25'd0, obs[d]}, {25'd0, exp_seg[d]});
    endtask

    initial begin
        int         lat;
        int         pulses;
        logic       saw_activity;
        logic [15:0] first_bcd;
        logic [15:0] second_bcd;
        logic [3:0]  exp_sel;

        vecs[0] = '{10'd137,  16'h0137, {7'b1111111, 7'b1111001, 7'b0110000, 7'b1111000}};
        vecs[1] = '{10'd1023, 16'h1023, {7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000}};
        vecs[2] = '{10'd7,    16'h0007, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
        vecs[3] = '{10'd500,  16'h0500, {7'b1111111, 7'b0010010, 7'b1000000, 7'b1000000}};
        vecs[4] = '{10'd40,   16'h0040, {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000}};
        vecs[5] = '{10'd999,  16'h0999, {7'b1111111, 7'b0010000, 7'b0010000, 7'b0010000}};
        vecs[6] = '{10'd0,    16'h0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};

        // ---------------- Reset state ----------------
        reset = 1'b0;
        score = 10'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset bcd",       {16'd0, bcd},       32'h0000);
        chk("reset busy",      {31'd0, busy},      32'd0);
        chk("reset conv_done", {31'd0, conv_done}, 32'd0);
        chk("reset digit_sel", {28'd0, digit_sel}, 32'he);
        chk("reset seg",       {25'd0, seg},       32'h40);

        // ---------------- Idle scan with score 0 ----------------
        reset = 1'b1;
        saw_activity = 1'b0;
        for (int j = 0; j < 16; j++) begin
            exp_sel = ~(4'b0001 << (j / 4));
            chk($sformatf("idle digit_sel cyc%0d", j), {28'd0, digit_sel}, {28'd0, exp_sel});
            chk($sformatf("idle seg cyc%0d", j), {25'd0, seg},
                (j < 4) ? 32'h40 : 32'h7f);
            if (busy || conv_done) saw_activity = 1'b1;
            @(posedge clock);
            @(negedge clock);
        end
        chk("idle no conversion", {31'd0, saw_activity}, 32'd0);
        chk("idle bcd", {16'd0, bcd}, 32'h0000);

        // ---------------- Table-driven conversions ----------------
        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].score, lat);
            chk($sformatf("latency score=%0d", vecs[i].score), lat, 32'd11);
            chk($sformatf("bcd score=%0d", vecs[i].score), {16'd0, bcd}, {16'd0, vecs[i].bcd});
            scan_check(vecs[i].seg, $sformatf("score=%0d", vecs[i].score));
        end

        // ---------------- Score changes while busy ----------------
        score      = 10'd5;
        pulses     = 0;
        first_bcd  = 16'hffff;
        second_bcd = 16'hffff;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (conv_done) begin
                pulses++;
                if (pulses == 1) first_bcd = bcd;
                if (pulses == 2) second_bcd = bcd;
            end
            if (k == 3) score = 10'd9;
        end
        chk("busy-change pulse count", pulses, 32'd2);
        chk("busy-change first bcd",  {16'd0, first_bcd},  32'h0005);
        chk("busy-change second bcd", {16'd0, second_bcd}, 32'h0009);
        chk("busy-change final bcd",  {16'd0, bcd},        32'h0009);

        // ---------------- Reset during a conversion ----------------
        score = 10'd500;
        @(posedge clock);
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midreset bcd",       {16'd0, bcd},       32'h0000);
        chk("midreset busy",      {31'd0, busy},      32'd0);
        chk("midreset conv_done", {31'd0, conv_done}, 32'd0);
        chk("midreset digit_sel", {28'd0, digit_sel}, 32'he);
        chk("midreset seg",       {25'd0, seg},       32'h40);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wait_conv(lat);
        chk("post-reset latency", lat, 32'd11);
        chk("post-reset bcd", {16'd0, bcd}, 32'h0500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit stays enabled (legal 2..65535).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port score  input  10  binary score from the brick/score logic (0..1023).
REQ-005 SHALL have port bcd  output  16  last converted value, 4 BCD digits, [15:12]=thousands.
REQ-006 SHALL have port conv_done  output  1  one-cycle pulse when bcd updates.
REQ-007 SHALL have port busy  output  1  high while a conversion runs.
REQ-008 SHALL have port seg  output  7  active-low segments, seg[0]=a ... seg[6]=g.
REQ-009 SHALL have port digit_sel  output  4  active-low one-hot digit enable, bit0=units.

Function
REQ-010 SHALL hold a registered copy last_score of the most recently accepted score.
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-012 IDLE: when score != last_score, SHALL latch score into last_score and the shift register, clear the BCD accumulator, go to SHIFT; otherwise stay.
REQ-013 SHIFT SHALL run exactly 10 cycles of shift-add-3 (add 3 to any BCD nibble >= 5, then shift left one bit), then go to DONE.
REQ-014 DONE SHALL load bcd, pulse conv_done for exactly that cycle, return to IDLE.
REQ-015 Latency: score change sampled in cycle N -> bcd valid and conv_done high in cycle N+11.
REQ-016 busy SHALL be high in SHIFT and DONE, low in IDLE.
REQ-017 score changes while busy SHALL be ignored; on return to IDLE the comparison SHALL be redone, so the final stable score is always displayed.
REQ-018 bcd[15:13] SHALL always be 0 (max 1023); bcd SHALL never show a non-BCD nibble.
REQ-019 Scan counter SHALL count 0..SCAN_DIV-1 then wrap, advancing digit index 0->1->2->3->0 on wrap.
REQ-020 digit_sel SHALL be registered, one bit low at all times, matching digit index.
REQ-021 seg SHALL be registered from the selected bcd nibble via fixed 0-9 decode (0 = 7'b1000000).
REQ-022 Leading-zero blanking: a digit above units SHALL show seg=7'b1111111 when it and all higher digits are 0; units SHALL never be blanked.
REQ-023 The displayed digits SHALL come only from bcd, never from in-progress accumulator state.

Reset
REQ-024 reset low SHALL asynchronously force: state IDLE, last_score 0, bcd 16'h0000, conv_done 0, busy 0, scan counter 0, digit index 0, digit_sel 4'b1110, seg 7'b1000000.
REQ-025 reset mid-conversion SHALL abandon it; bcd stays 0 and no conv_done issues until a new nonzero score is seen.
REQ-026 After reset release with score=0, no conversion SHALL start.

Structure
REQ-027 Package score_display_pkg SHALL hold the FSM state type, DIGITS=4, SCORE_W=10, SEG_BLANK, and the 0-9 segment table.
REQ-028 Conversion SHALL live in sub-module bin2bcd_seq (start/value in, busy/done/bcd out); scan and decode stay in score_display.

Verification (SCAN_DIV=4 in bench)
REQ-029 Reset release, score=0 -> bcd=16'h0000, busy never high, units shows 7'b1000000, other digits 7'b1111111.
REQ-030 score 0->137 -> conv_done exactly 11 cycles later, bcd=16'h0137; thousands blanked, hundreds '1' (7'b1111001).
REQ-031 score=1023 -> bcd=16'h1023, all four digits lit over one 16-cycle scan period.
REQ-032 score 5, changed to 9 three cycles later -> bcd=16'h0005 with pulse, then second conversion, bcd=16'h0009; exactly two conv_done pulses.
REQ-033 score=7 -> digit_sel cycles 1110,1101,1011,0111 every 4 cycles; only units non-blank.
REQ-034 reset asserted during SHIFT of score=500 -> outputs at reset values immediately; after release conversion restarts, bcd=16'h0500 at release+11 cycles.
